// File: rtl/mel_filterbank.sv
// Mel filterbank: per-bin power, 8 triangular mel bands, double-buffered drain.
// Define MEL_LOG_COMPRESS_EN to emit a log2 approximation instead of linear energy.
module mel_filterbank #(
  parameter int DATA_WIDTH = 16,
  parameter int FFT_SIZE   = 32,
  parameter int NUM_MEL    = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] data_real_in,
  input  logic signed [DATA_WIDTH-1:0] data_imag_in,
  output logic                         mel_valid,
  input  logic                         mel_ready,
  output logic [2:0]                   mel_index,
  output logic [ACC_WIDTH-1:0]         mel_energy,
  output logic                         frame_last,
  output logic                         overflow
);

  localparam logic [4:0] LAST_BIN = 5'(FFT_SIZE - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_MEL - 1);

  localparam logic [0:0] ACCUM    = 1'b0;
  localparam logic [0:0] COMMIT   = 1'b1;
  localparam logic [0:0] OUT_IDLE = 1'b0;
  localparam logic [0:0] OUT_SEND = 1'b1;

  logic [4:0]           r_bin;
  logic                 r_s1_valid;
  logic [4:0]           r_s1_bin;
  logic [ACC_WIDTH-1:0] r_s1_p;
  logic [0:0]           r_acc_state;
  logic [0:0]           r_out_state;
  logic [2:0]           r_idx;
  logic                 r_overflow;
  logic [ACC_WIDTH-1:0] r_acc [NUM_MEL];
  logic [ACC_WIDTH-1:0] r_buf [NUM_MEL];

  logic signed [ACC_WIDTH-1:0] w_re;
  logic signed [ACC_WIDTH-1:0] w_im;
  logic [ACC_WIDTH-1:0]        w_p;

  assign w_re = ACC_WIDTH'(data_real_in);
  assign w_im = ACC_WIDTH'(data_imag_in);
  assign w_p  = $unsigned(w_re * w_re) + $unsigned(w_im * w_im);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bin      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_bin   <= '0;
      r_s1_p     <= '0;
    end else begin
      r_s1_valid <= valid_in;
      if (valid_in) begin
        r_bin    <= r_bin + 5'd1;
        r_s1_bin <= r_bin;
        r_s1_p   <= w_p;
      end
    end
  end

  // Each bin feeds at most two filters: slot a and slot b.
  logic [2:0] w_fa;
  logic [7:0] w_wa;
  logic [2:0] w_fb;
  logic [7:0] w_wb;

  always_comb begin
    w_fa = 3'd0;
    w_wa = 8'd0;
    w_fb = 3'd0;
    w_wb = 8'd0;
    case (r_s1_bin)
      5'd1:  begin w_fa = 3'd0; w_wa = 8'd128; end
      5'd2:  begin w_fa = 3'd1; w_wa = 8'd128; end
      5'd3:  begin w_fa = 3'd2; w_wa = 8'd128; end
      5'd4:  begin w_fa = 3'd3; w_wa = 8'd128; end
      5'd5:  begin
        w_fa = 3'd3; w_wa = 8'd64;
        w_fb = 3'd4; w_wb = 8'd64;
      end
      5'd6:  begin w_fa = 3'd4; w_wa = 8'd128; end
      5'd7:  begin
        w_fa = 3'd4; w_wa = 8'd64;
        w_fb = 3'd5; w_wb = 8'd64;
      end
      5'd8:  begin w_fa = 3'd5; w_wa = 8'd128; end
      5'd9:  begin
        w_fa = 3'd5; w_wa = 8'd64;
        w_fb = 3'd6; w_wb = 8'd64;
      end
      5'd10: begin w_fa = 3'd6; w_wa = 8'd128; end
      5'd11: begin
        w_fa = 3'd6; w_wa = 8'd85;
        w_fb = 3'd7; w_wb = 8'd42;
      end
      5'd12: begin
        w_fa = 3'd6; w_wa = 8'd42;
        w_fb = 3'd7; w_wb = 8'd85;
      end
      5'd13: begin w_fa = 3'd7; w_wa = 8'd128; end
      5'd14: begin w_fa = 3'd7; w_wa = 8'd85; end
      5'd15: begin w_fa = 3'd7; w_wa = 8'd42; end
      default: ;
    endcase
  end

  logic [ACC_WIDTH+7:0] w_prod_a;
  logic [ACC_WIDTH+7:0] w_prod_b;
  logic [ACC_WIDTH-1:0] w_term_a;
  logic [ACC_WIDTH-1:0] w_term_b;

  assign w_prod_a = (ACC_WIDTH+8)'(r_s1_p) * (ACC_WIDTH+8)'(w_wa);
  assign w_prod_b = (ACC_WIDTH+8)'(r_s1_p) * (ACC_WIDTH+8)'(w_wb);
  assign w_term_a = ACC_WIDTH'(w_prod_a >> 7);
  assign w_term_b = ACC_WIDTH'(w_prod_b >> 7);

  logic w_last2;
  logic w_commit;
  logic w_xfer;
  logic w_done;
  logic w_free;

  assign w_last2  = r_s1_valid && (r_s1_bin == LAST_BIN);
  assign w_commit = (r_acc_state == COMMIT);
  assign w_xfer   = mel_valid && mel_ready;
  assign w_done   = w_xfer && (r_idx == LAST_IDX);
  assign w_free   = (r_out_state == OUT_IDLE) || w_done;

  logic [ACC_WIDTH-1:0] w_add  [NUM_MEL];
  logic [ACC_WIDTH-1:0] w_base [NUM_MEL];
  logic [ACC_WIDTH:0]   w_sum  [NUM_MEL];
  logic [ACC_WIDTH-1:0] w_nxt  [NUM_MEL];

  // Commit zeroes the base so a new frame's bin 0 lands on clean accumulators.
  always_comb begin
    for (int m = 0; m < NUM_MEL; m++) begin
      w_add[m] = '0;
      if (r_s1_valid && w_fa == 3'(m))
        w_add[m] = w_term_a;
      else if (r_s1_valid && w_fb == 3'(m))
        w_add[m] = w_term_b;
      w_base[m] = w_commit ? '0 : r_acc[m];
      w_sum[m]  = {1'b0, w_base[m]} + {1'b0, w_add[m]};
      w_nxt[m]  = w_sum[m][ACC_WIDTH] ? '1 : w_sum[m][ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc_state <= ACCUM;
      for (int m = 0; m < NUM_MEL; m++)
        r_acc[m] <= '0;
    end else begin
      r_acc_state <= (!w_commit && w_last2) ? COMMIT : ACCUM;
      for (int m = 0; m < NUM_MEL; m++)
        r_acc[m] <= w_nxt[m];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_state <= OUT_IDLE;
      r_idx       <= '0;
      r_overflow  <= 1'b0;
      for (int m = 0; m < NUM_MEL; m++)
        r_buf[m] <= '0;
    end else begin
      r_overflow <= w_commit && !w_free;
      if (w_commit && w_free) begin
        r_out_state <= OUT_SEND;
        r_idx       <= '0;
        for (int m = 0; m < NUM_MEL; m++)
          r_buf[m] <= r_acc[m];
      end else if (w_done) begin
        r_out_state <= OUT_IDLE;
        r_idx       <= '0;
      end else if (w_xfer) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  logic [ACC_WIDTH-1:0] w_sel;
  assign w_sel = r_buf[r_idx];

`ifdef MEL_LOG_COMPRESS_EN
  function automatic logic [ACC_WIDTH-1:0] f_log2(
    input logic [ACC_WIDTH-1:0] e
  );
    logic [4:0] ex;
    logic [4:0] mant;
    ex = '0;
    for (int i = 0; i < ACC_WIDTH; i++)
      if (e[i]) ex = 5'(i);
    if (ex >= 5'd5)
      mant = 5'(e >> (ex - 5'd5));
    else
      mant = 5'(e << (5'd5 - ex));
    f_log2 = (e == '0) ? '0 : ACC_WIDTH'({ex, mant});
  endfunction

  logic [ACC_WIDTH-1:0] w_val;
  assign w_val = f_log2(w_sel);
`else
  logic [ACC_WIDTH-1:0] w_val;
  assign w_val = w_sel;
`endif

  assign mel_valid  = (r_out_state == OUT_SEND);
  assign mel_index  = r_idx;
  assign mel_energy = mel_valid ? w_val : '0;
  assign frame_last = mel_valid && (r_idx == LAST_IDX);
  assign overflow   = r_overflow;

endmodule
